// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I control unit: state enum, opcodes
// and the datapath mux/ALU select codes driven by the controller.
package rv_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_JALR     = 4'd11,
    S_JALRWB   = 4'd12,
    S_HALT     = 4'd13
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;
  localparam logic [2:0] ALU_SLL = 3'b110;
  localparam logic [2:0] ALU_SRL = 3'b111;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_A     = 2'b10;

  localparam logic [1:0] SRCB_B    = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

endpackage

// File: rtl/alu_decoder.sv
// Maps funct3/funct7_5 of R- and I-type ALU instructions onto the ALU
// operation code; flags funct3 values this core does not implement.
module alu_decoder
  import rv_ctrl_pkg::*;
(
  input  logic       is_rtype,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  output logic [2:0] alu_control,
  output logic       unsupported
);

  // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    alu_control = ALU_ADD;
    unsupported = 1'b0;
    case (funct3)
      3'b000:  alu_control = (is_rtype && funct7_5) ? ALU_SUB : ALU_ADD;
      3'b001:  alu_control = ALU_SLL;
      3'b010:  alu_control = ALU_SLT;
      3'b011:  unsupported = 1'b1;  // sltu/sltiu have no ALU op here
      3'b100:  alu_control = ALU_XOR;
      3'b101:  alu_control = ALU_SRL;
      3'b110:  alu_control = ALU_OR;
      default: alu_control = ALU_AND;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RV32I sequencer: walks each instruction through fetch, decode,
// execute and writeback states, handshaking with the shared memory.
module multicycle_controller
  import rv_ctrl_pkg::*;
#(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [6:0]           op,
  input  logic [2:0]           funct3,
  input  logic                 funct7_5,
  input  logic                 Zero,
  input  logic                 mem_ready,
  output logic                 mem_req,
  output logic                 MemWrite,
  output logic                 AdrSrc,
  output logic                 IRWrite,
  output logic                 PCWrite,
  output logic                 RegWrite,
  output logic [1:0]           ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic [2:0]           ALUControl,
  output logic [1:0]           ResultSrc,
  output logic [1:0]           ImmSrc,
  output logic [3:0]           state,
  output logic                 retire,
  output logic [CNT_WIDTH-1:0] retired_cnt,
  output logic                 illegal
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  state_t state_q, next_state;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic [2:0] dec_alu;
  logic       dec_unsupported;
  logic       mem_req_c, mem_write_c, ir_write_c, pc_write_c, reg_write_c, retire_c;

  alu_decoder u_alu_decoder (
    .is_rtype    (op == OP_R),
    .funct3      (funct3),
    .funct7_5    (funct7_5),
    .alu_control (dec_alu),
    .unsupported (dec_unsupported)
  );

  // NOTE: state and counter use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= next_state;
      if (retire_c) cnt_q <= cnt_q + CNT_ONE;
    end
  end

  always_comb begin
    next_state  = state_q;
    mem_req_c   = 1'b0;
    mem_write_c = 1'b0;
    ir_write_c  = 1'b0;
    pc_write_c  = 1'b0;
    reg_write_c = 1'b0;
    AdrSrc      = 1'b0;
    ALUSrcA     = SRCA_PC;
    ALUSrcB     = SRCB_B;
    ALUControl  = ALU_ADD;
    ResultSrc   = RES_ALUOUT;
    case (state_q)
      S_FETCH: begin
        mem_req_c = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
        if (mem_ready) begin
          ir_write_c = 1'b1;
          pc_write_c = 1'b1;
          next_state = S_DECODE;
        end
      end
      S_DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        case (op)
          OP_LOAD, OP_STORE: next_state = (funct3 == 3'b010) ? S_MEMADR : S_HALT;
          OP_R:              next_state = dec_unsupported ? S_HALT : S_EXECR;
          OP_I:              next_state = dec_unsupported ? S_HALT : S_EXECI;
          OP_BRANCH:         next_state = (funct3[2:1] == 2'b00) ? S_BRANCH : S_HALT;
          OP_JAL:            next_state = S_JAL;
          OP_JALR:           next_state = S_JALR;
          default:           next_state = S_HALT;
        endcase
      end
      S_MEMADR: begin
        ALUSrcA    = SRCA_A;
        ALUSrcB    = SRCB_IMM;
        next_state = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        mem_req_c = 1'b1;
        AdrSrc    = 1'b1;
        if (mem_ready) next_state = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc   = RES_DATA;
        reg_write_c = 1'b1;
        next_state  = S_FETCH;
      end
      S_MEMWRITE: begin
        mem_req_c   = 1'b1;
        mem_write_c = 1'b1;
        AdrSrc      = 1'b1;
        if (mem_ready) next_state = S_FETCH;
      end
      S_EXECR: begin
        ALUSrcA    = SRCA_A;
        ALUControl = dec_alu;
        next_state = S_ALUWB;
      end
      S_EXECI: begin
        ALUSrcA    = SRCA_A;
        ALUSrcB    = SRCB_IMM;
        ALUControl = dec_alu;
        next_state = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write_c = 1'b1;
        next_state  = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA    = SRCA_A;
        ALUControl = ALU_SUB;
        pc_write_c = funct3[0] ? ~Zero : Zero;  // funct3[0]: 0 = beq, 1 = bne
        next_state = S_FETCH;
      end
      S_JAL: begin
        ALUSrcA    = SRCA_OLDPC;
        ALUSrcB    = SRCB_FOUR;
        pc_write_c = 1'b1;
        next_state = S_ALUWB;
      end
      S_JALR: begin
        ALUSrcA    = SRCA_A;
        ALUSrcB    = SRCB_IMM;
        ResultSrc  = RES_ALURESULT;
        pc_write_c = 1'b1;
        next_state = S_JALRWB;
      end
      S_JALRWB: begin
        ALUSrcA     = SRCA_OLDPC;
        ALUSrcB     = SRCB_FOUR;
        ResultSrc   = RES_ALURESULT;
        reg_write_c = 1'b1;
        next_state  = S_FETCH;
      end
      default: next_state = S_HALT;
    endcase
  end

  always_comb begin
    ImmSrc = IMM_I;
    case (op)
      OP_STORE:  ImmSrc = IMM_S;
      OP_BRANCH: ImmSrc = IMM_B;
      OP_JAL:    ImmSrc = IMM_J;
      default:   ImmSrc = IMM_I;
    endcase
  end

  assign retire_c = (state_q != S_FETCH) && (next_state == S_FETCH);

  // Strobes are gated by rst so an in-flight access drops the moment reset asserts.
  assign mem_req     = mem_req_c   & rst;
  assign MemWrite    = mem_write_c & rst;
  assign IRWrite     = ir_write_c  & rst;
  assign PCWrite     = pc_write_c  & rst;
  assign RegWrite    = reg_write_c & rst;
  assign retire      = retire_c    & rst;
  assign state       = state_q;
  assign retired_cnt = cnt_q;
  assign illegal     = (state_q == S_HALT);

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: a vector table of whole
// instructions plus hand-written sequences for stalls, halt and reset.
module tb_multicycle_controller;
  import rv_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  op;
  logic [2:0]  funct3;
  logic        funct7_5;
  logic        Zero;
  logic        mem_ready;
  logic        mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite;
  logic [1:0]  ALUSrcA, ALUSrcB, ResultSrc, ImmSrc;
  logic [2:0]  ALUControl;
  logic [3:0]  state;
  logic        retire;
  logic [31:0] retired_cnt;
  logic        illegal;

  int checks   = 0;
  int failures = 0;

  multicycle_controller #(.CNT_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7_5(funct7_5),
    .Zero(Zero), .mem_ready(mem_ready), .mem_req(mem_req), .MemWrite(MemWrite),
    .AdrSrc(AdrSrc), .IRWrite(IRWrite), .PCWrite(PCWrite), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUControl(ALUControl),
    .ResultSrc(ResultSrc), .ImmSrc(ImmSrc), .state(state), .retire(retire),
    .retired_cnt(retired_cnt), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0] op;
    logic [2:0] f3;
    logic       f7;
    logic       z;
    int         lat;
    logic [2:0] alu3;
    logic       pcw3;
    logic [1:0] imm;
  } vec_t;

  vec_t vecs[18];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Runs one instruction with mem_ready high; samples ImmSrc in cycle 1 and
  // ALUControl/PCWrite in cycle 3, stops after the retire cycle.
  task automatic run_vec(input vec_t v, output int cycles, output logic [2:0] alu3,
                         output logic pcw3, output logic [1:0] imm1);
    bit done;
    done = 1'b0;
    op = v.op; funct3 = v.f3; funct7_5 = v.f7; Zero = v.z; mem_ready = 1'b1;
    cycles = 0; alu3 = '0; pcw3 = 1'b0; imm1 = '0;
    while (!done && cycles < 12) begin
      @(negedge clk);
      cycles++;
      if (cycles == 1) imm1 = ImmSrc;
      if (cycles == 3) begin
        alu3 = ALUControl;
        pcw3 = PCWrite;
      end
      done = retire;
      next_cycle();
    end
  endtask

  initial begin
    int         cyc;
    logic [2:0] alu3;
    logic       pcw3;
    logic [1:0] imm1;
    int         regw, ret, mreq_rd, early, strobes;
    int         exp_cnt;
    logic [3:0] add_st[4];
    logic [3:0] lw_st[8];
    logic       lw_mr[8];

    vecs[0]  = '{OP_R,      3'b000, 1'b0, 1'b0, 4, ALU_ADD, 1'b0, IMM_I};
    vecs[1]  = '{OP_R,      3'b000, 1'b1, 1'b0, 4, ALU_SUB, 1'b0, IMM_I};
    vecs[2]  = '{OP_R,      3'b001, 1'b0, 1'b0, 4, ALU_SLL, 1'b0, IMM_I};
    vecs[3]  = '{OP_R,      3'b010, 1'b0, 1'b0, 4, ALU_SLT, 1'b0, IMM_I};
    vecs[4]  = '{OP_R,      3'b100, 1'b0, 1'b0, 4, ALU_XOR, 1'b0, IMM_I};
    vecs[5]  = '{OP_R,      3'b101, 1'b0, 1'b0, 4, ALU_SRL, 1'b0, IMM_I};
    vecs[6]  = '{OP_R,      3'b110, 1'b0, 1'b0, 4, ALU_OR,  1'b0, IMM_I};
    vecs[7]  = '{OP_R,      3'b111, 1'b0, 1'b0, 4, ALU_AND, 1'b0, IMM_I};
    vecs[8]  = '{OP_I,      3'b000, 1'b1, 1'b0, 4, ALU_ADD, 1'b0, IMM_I};
    vecs[9]  = '{OP_I,      3'b110, 1'b0, 1'b0, 4, ALU_OR,  1'b0, IMM_I};
    vecs[10] = '{OP_LOAD,   3'b010, 1'b0, 1'b0, 5, ALU_ADD, 1'b0, IMM_I};
    vecs[11] = '{OP_STORE,  3'b010, 1'b0, 1'b0, 4, ALU_ADD, 1'b0, IMM_S};
    vecs[12] = '{OP_BRANCH, 3'b000, 1'b0, 1'b1, 3, ALU_SUB, 1'b1, IMM_B};
    vecs[13] = '{OP_BRANCH, 3'b000, 1'b0, 1'b0, 3, ALU_SUB, 1'b0, IMM_B};
    vecs[14] = '{OP_BRANCH, 3'b001, 1'b0, 1'b1, 3, ALU_SUB, 1'b0, IMM_B};
    vecs[15] = '{OP_BRANCH, 3'b001, 1'b0, 1'b0, 3, ALU_SUB, 1'b1, IMM_B};
    vecs[16] = '{OP_JAL,    3'b000, 1'b0, 1'b0, 4, ALU_ADD, 1'b1, IMM_J};
    vecs[17] = '{OP_JALR,   3'b000, 1'b0, 1'b0, 4, ALU_ADD, 1'b1, IMM_I};

    add_st = '{S_FETCH, S_DECODE, S_EXECR, S_ALUWB};
    lw_st  = '{S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMREAD, S_MEMREAD, S_MEMREAD, S_MEMWB};
    lw_mr  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    rst = 1'b0; op = '0; funct3 = '0; funct7_5 = 1'b0; Zero = 1'b0; mem_ready = 1'b1;

    // Reset: FETCH would request memory, but strobes are held low.
    @(negedge clk);
    check("rst_state", state, S_FETCH);
    check("rst_mem_req", mem_req, 0);
    check("rst_irwrite", IRWrite, 0);
    check("rst_cnt", retired_cnt, 0);
    check("rst_illegal", illegal, 0);
    next_cycle();
    rst = 1'b1;
    exp_cnt = 0;

    // add x3,x1,x2
    op = OP_R; funct3 = 3'b000; funct7_5 = 1'b0; mem_ready = 1'b1;
    regw = 0; ret = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check($sformatf("add_state%0d", c), state, add_st[c]);
      if (c == 2) check("add_aluctl", ALUControl, ALU_ADD);
      regw += int'(RegWrite);
      ret  += int'(retire);
      next_cycle();
    end
    exp_cnt++;
    check("add_regwrite_cycles", regw, 1);
    check("add_retire_cycles", ret, 1);
    check("add_cnt", retired_cnt, exp_cnt);

    // Table of single instructions with mem_ready tied high.
    for (int i = 0; i < 18; i++) begin
      run_vec(vecs[i], cyc, alu3, pcw3, imm1);
      exp_cnt++;
      check($sformatf("vec%0d_latency", i), cyc, vecs[i].lat);
      check($sformatf("vec%0d_aluctl", i), alu3, vecs[i].alu3);
      check($sformatf("vec%0d_pcwrite", i), pcw3, vecs[i].pcw3);
      check($sformatf("vec%0d_immsrc", i), imm1, vecs[i].imm);
      check($sformatf("vec%0d_cnt", i), retired_cnt, exp_cnt);
    end

    // lw with three wait cycles in MEMREAD; mem_ready toggles are ignored elsewhere.
    op = OP_LOAD; funct3 = 3'b010; mreq_rd = 0; early = 0;
    for (int c = 0; c < 8; c++) begin
      mem_ready = lw_mr[c];
      @(negedge clk);
      check($sformatf("lw_state%0d", c), state, lw_st[c]);
      if (state == S_MEMREAD) mreq_rd += int'(mem_req);
      if (c < 7 && RegWrite) early++;
      if (c == 7) begin
        check("lw_regwrite_wb", RegWrite, 1);
        check("lw_retire_wb", retire, 1);
      end
      next_cycle();
    end
    exp_cnt++;
    check("lw_memreq_cycles", mreq_rd, 4);
    check("lw_early_regwrite", early, 0);
    check("lw_cnt", retired_cnt, exp_cnt);

    // jalr: PC written in JALR, link written in JALRWB.
    op = OP_JALR; funct3 = 3'b000; mem_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (c == 2) begin
        check("jalr_state", state, S_JALR);
        check("jalr_pcwrite", PCWrite, 1);
        check("jalr_resultsrc", ResultSrc, RES_ALURESULT);
        check("jalr_regwrite", RegWrite, 0);
      end
      if (c == 3) begin
        check("jalrwb_state", state, S_JALRWB);
        check("jalrwb_regwrite", RegWrite, 1);
        check("jalrwb_srca", ALUSrcA, SRCA_OLDPC);
        check("jalrwb_srcb", ALUSrcB, SRCB_FOUR);
        check("jalrwb_pcwrite", PCWrite, 0);
        check("jalrwb_retire", retire, 1);
      end
      next_cycle();
    end
    exp_cnt++;
    check("jalr_cnt", retired_cnt, exp_cnt);

    // sw stalled in MEMWRITE, then reset asserted mid-wait.
    op = OP_STORE; funct3 = 3'b010; mem_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      if (c == 1) mem_ready = 1'b0;
      @(negedge clk);
      if (c < 3) next_cycle();
    end
    check("sw_wait_state", state, S_MEMWRITE);
    check("sw_wait_memwrite", MemWrite, 1);
    check("sw_wait_memreq", mem_req, 1);
    #1 rst = 1'b0;
    #1;
    check("sw_rst_memwrite", MemWrite, 0);
    check("sw_rst_memreq", mem_req, 0);
    check("sw_rst_state", state, S_FETCH);
    check("sw_rst_cnt", retired_cnt, 0);
    #1 rst = 1'b1;
    @(negedge clk);
    check("sw_release_state", state, S_FETCH);
    check("sw_release_cnt", retired_cnt, 0);
    next_cycle();

    // Opcode 0x7F halts; nothing moves for 20 cycles.
    op = 7'h7F; funct3 = 3'b000; mem_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (c < 2) next_cycle();
    end
    check("halt7f_state", state, S_HALT);
    check("halt7f_illegal", illegal, 1);
    next_cycle();
    op = OP_R; strobes = 0;
    for (int c = 0; c < 20; c++) begin
      mem_ready = c[0];
      @(negedge clk);
      strobes += int'(mem_req | MemWrite | IRWrite | PCWrite | RegWrite | retire);
      next_cycle();
    end
    check("halt7f_strobes", strobes, 0);
    check("halt7f_state_held", state, S_HALT);
    check("halt7f_illegal_held", illegal, 1);
    check("halt7f_cnt", retired_cnt, 0);

    // Reset clears the halt; R-type with funct3=011 halts again after a FETCH stall.
    rst = 1'b0;
    @(negedge clk);
    check("halt_rst_illegal", illegal, 0);
    next_cycle();
    rst = 1'b1;
    op = OP_R; funct3 = 3'b011; mem_ready = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      check($sformatf("fetch_stall_state%0d", c), state, S_FETCH);
      check($sformatf("fetch_stall_memreq%0d", c), mem_req, 1);
      check($sformatf("fetch_stall_irwrite%0d", c), IRWrite, 0);
      next_cycle();
    end
    mem_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (c < 2) next_cycle();
    end
    check("halt_sltu_state", state, S_HALT);
    check("halt_sltu_illegal", illegal, 1);
    check("halt_sltu_cnt", retired_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
